// File: rtl/ulpi_pkg.sv
// Shared types for the ULPI receive path: RX CMD event decode, framed word
// layout and framer states.
package ulpi_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    EV_INACTIVE   = 2'b00,
    EV_ACTIVE     = 2'b01,
    EV_DISCONNECT = 2'b10,
    EV_ERROR      = 2'b11
  } rx_event_e;

  typedef struct packed {
    logic              err;
    logic              eop;
    logic              sop;
    logic [DATA_W-1:0] data;
  } rx_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EOP_WAIT
  } framer_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// First-word-fall-through FIFO; a write into a full FIFO is accepted only when
// a read frees a slot in the same cycle.
module ulpi_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit separates full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ulpi_rx_framer.sv
// Frames ULPI receive bytes into sop/eop/err-marked words behind an output
// FIFO, with one byte of holdback so eop lands on the true last byte.
module ulpi_rx_framer
  import ulpi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_PKT_LEN = 1027
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_cmd,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic [7:0]  m_data,
  output logic        m_sop,
  output logic        m_eop,
  output logic        m_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int unsigned CNT_W  = $clog2(MAX_PKT_LEN + 2);
  localparam int unsigned WORD_W = $bits(rx_word_t);

  framer_state_e    state_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic             first_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  rx_word_t         eop_word_q;
  logic             act_q;

  logic     rx_active;
  logic     rx_error;
  logic     rx_cmd_unused;
  logic     fifo_full;
  logic     fifo_empty;
  logic     can_push;
  logic     take_byte;
  logic     babble;
  logic     mid_push;
  logic     mid_lost;
  logic     has_fin;
  logic     err_c;
  logic     wr_en;
  logic     drop_c;
  rx_word_t wr_word;
  rx_word_t fin_word;
  rx_word_t rd_word;

  assign rx_active     = rx_cmd[4];
  assign rx_error      = (rx_event_e'(rx_cmd[5:4]) == EV_ERROR);
  assign rx_cmd_unused = ^{rx_cmd[7:6], rx_cmd[3:0]};
  assign can_push      = !fifo_full || (m_ready && !fifo_empty);

  // Push decision: a held byte moves out mid-packet, or the eop word at the end
  always_comb begin
    wr_en     = 1'b0;
    wr_word   = '0;
    mid_push  = 1'b0;
    mid_lost  = 1'b0;
    has_fin   = 1'b0;
    err_c     = err_q;
    fin_word  = '0;
    take_byte = (state_q == ST_ACTIVE) && rx_data_valid && (cnt_q < CNT_W'(MAX_PKT_LEN));
    babble    = (state_q == ST_ACTIVE) && rx_data_valid && !(cnt_q < CNT_W'(MAX_PKT_LEN));
    case (state_q)
      ST_ACTIVE: begin
        mid_push      = take_byte && hold_full_q;
        mid_lost      = mid_push && !can_push;
        err_c         = err_q || rx_error || babble || mid_lost;
        has_fin       = take_byte || hold_full_q;
        fin_word.err  = err_c;
        fin_word.eop  = 1'b1;
        fin_word.sop  = take_byte ? (first_q && !hold_full_q) : first_q;
        fin_word.data = take_byte ? rx_data : hold_q;
        if (mid_push) begin
          wr_en   = can_push;
          wr_word = '{err: 1'b0, eop: 1'b0, sop: first_q, data: hold_q};
        end else if (!rx_active && has_fin) begin
          wr_en   = can_push;
          wr_word = fin_word;
        end
      end
      ST_EOP_WAIT: begin
        wr_en   = can_push;
        wr_word = eop_word_q;
      end
      default: ;
    endcase
    drop_c = (rx_data_valid && (state_q != ST_ACTIVE)) || babble || mid_lost;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      eop_word_q  <= '0;
      act_q       <= 1'b1;
      pkt_count   <= '0;
      drop_count  <= '0;
      busy        <= 1'b0;
    end else begin
      act_q <= rx_active;
      if (wr_en && wr_word.eop) pkt_count <= sat_inc16(pkt_count);
      if (drop_c) drop_count <= sat_inc16(drop_count);
      case (state_q)
        // Only a fresh rising RxActive starts a packet, so one that began
        // while still flushing the previous eop is dropped whole
        ST_IDLE: begin
          if (rx_active && !act_q) begin
            state_q     <= ST_ACTIVE;
            busy        <= 1'b1;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            hold_full_q <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          err_q <= err_c;
          if (rx_data_valid && (cnt_q <= CNT_W'(MAX_PKT_LEN))) cnt_q <= cnt_q + CNT_W'(1);
          if (take_byte) begin
            hold_q      <= rx_data;
            hold_full_q <= 1'b1;
          end
          if (mid_push && can_push) first_q <= 1'b0;
          if (!rx_active) begin
            hold_full_q <= 1'b0;
            if (has_fin && (mid_push || !can_push)) begin
              eop_word_q <= fin_word;
              state_q    <= ST_EOP_WAIT;
            end else begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_EOP_WAIT: begin
          if (can_push) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  ulpi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (rd_word),
    .empty   (fifo_empty)
  );

  assign m_data  = rd_word.data;
  assign m_sop   = rd_word.sop;
  assign m_eop   = rd_word.eop;
  assign m_err   = rd_word.err;
  assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Directed and randomized packets for ulpi_rx_framer, scored against a
// packet-level model of the expected framed word stream and statistics.
module tb_ulpi_rx_framer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MAXLEN = 1027;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_cmd;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [7:0]  m_data;
  logic        m_sop;
  logic        m_eop;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic        busy;

  always #5 clk = ~clk;

  ulpi_rx_framer #(
    .FIFO_DEPTH  (DEPTH),
    .MAX_PKT_LEN (MAXLEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_cmd        (rx_cmd),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .m_data        (m_data),
    .m_sop         (m_sop),
    .m_eop         (m_eop),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  typedef logic [10:0] word_t;  // {err, eop, sop, data}

  word_t      got_q[$];
  word_t      exp_q[$];
  logic [7:0] pkt[$];
  int         total = 0;
  int         bad = 0;
  int         exp_pkts = 0;
  int         exp_drops = 0;
  bit         rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record any handshake that happens at the coming edge
  task automatic tick();
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    if (m_valid && m_ready) got_q.push_back({m_err, m_eop, m_sop, m_data});
    @(posedge clk);
    #1;
  endtask

  // Packet-level model: up to MAXLEN bytes framed, the rest dropped as babble
  task automatic expect_pkt(input bit err);
    int n;
    bit babble;
    babble = (pkt.size() > int'(MAXLEN));
    n = babble ? int'(MAXLEN) : pkt.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1) && (err || babble), i == n - 1, i == 0, pkt[i]});
    if (n > 0) exp_pkts++;
    exp_drops += pkt.size() - n;
  endtask

  task automatic send(input int gap_max, input int err_at, input bit merge_end);
    rx_cmd = 8'h10;
    tick();
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == err_at) begin
        rx_cmd = 8'h30;
        tick();
      end
      rx_data       = pkt[i];
      rx_data_valid = 1'b1;
      if (merge_end && (i == pkt.size() - 1)) rx_cmd = 8'h00;
      tick();
      rx_data_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
    rx_cmd = 8'h00;
    tick();
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!m_valid && !busy) break;
      tick();
    end
    chk("drained", 32'({m_valid, busy}), 32'd0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_pkts"}, 32'(pkt_count), 32'(exp_pkts));
    chk({tag, "_drops"}, 32'(drop_count), 32'(exp_drops));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int err_at;
    bit merge;

    reset = 1'b1; rx_cmd = 8'h00; rx_data = 8'h00; rx_data_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'({m_err, m_eop, m_sop, m_data}), 32'd0);
    chk("rst_pkts", 32'(pkt_count), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic three-byte packet
    pkt = '{8'hC3, 8'h01, 8'h02};
    expect_pkt(1'b0);
    send(0, -1, 1'b0);
    drain();
    check_stream("basic");

    // RxError seen mid-packet marks the eop word
    pkt = '{8'h11, 8'h22, 8'h33};
    expect_pkt(1'b1);
    send(0, 2, 1'b0);
    drain();
    check_stream("rxerr");

    // Zero-length packet produces nothing
    pkt.delete();
    expect_pkt(1'b0);
    send(0, -1, 1'b0);
    drain();
    check_stream("zlp");

    // Strobe while idle is counted as a drop
    rx_data = 8'h5A; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    exp_drops++;
    tick();
    chk("idle_drop", 32'(drop_count), 32'(exp_drops));
    chk("idle_valid", 32'(m_valid), 32'd0);

    // Random short packets under random backpressure
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 12);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      err_at = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      merge  = 1'($urandom_range(0, 1));
      expect_pkt(err_at >= 0);
      rand_ready = 1'b1;
      send(2, err_at, merge);
      drain();
      check_stream("rand");
    end

    // Backpressure: FIFO fills, overflow bytes lost, eop waits for space
    m_ready = 1'b0;
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
    for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back({1'b0, 1'b0, i == 0, pkt[i]});
    exp_q.push_back({1'b1, 1'b1, 1'b0, pkt[19]});
    exp_drops += 20 - int'(DEPTH) - 1;
    rx_cmd = 8'h10;
    tick();
    for (int i = 0; i < 20; i++) begin
      rx_data = pkt[i]; rx_data_valid = 1'b1;
      tick();
    end
    rx_data_valid = 1'b0;
    rx_cmd = 8'h00;
    tick();
    chk("bp_wait_busy", 32'(busy), 32'd1);
    chk("bp_wait_valid", 32'(m_valid), 32'd1);
    chk("bp_wait_drops", 32'(drop_count), 32'(exp_drops));
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    exp_drops++;
    rx_cmd = 8'h10;
    tick();
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    exp_drops++;
    rx_cmd = 8'h00;
    tick();
    chk("bp_hold_pkts", 32'(pkt_count), 32'(exp_pkts));
    chk("bp_hold_busy", 32'(busy), 32'd1);
    exp_pkts++;
    drain();
    check_stream("bp");

    // Babble: bytes past the length limit are dropped, eop flagged corrupt
    pkt.delete();
    for (int i = 0; i < 1030; i++) pkt.push_back(8'($urandom));
    expect_pkt(1'b0);
    send(0, -1, 1'b0);
    drain();
    check_stream("babble");

    // Reset mid-packet discards everything
    m_ready = 1'b0;
    rx_cmd = 8'h10;
    tick();
    rx_data = 8'h01; rx_data_valid = 1'b1;
    tick();
    rx_data = 8'h02;
    tick();
    rx_data_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rx_cmd = 8'h00;
    tick();
    tick();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_pkts", 32'(pkt_count), 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_pkts = 0;
    exp_drops = 0;
    got_q.delete();
    m_ready = 1'b1;
    pkt = '{8'hAA, 8'hBB};
    expect_pkt(1'b0);
    send(0, -1, 1'b0);
    drain();
    check_stream("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
